// File: rtl/key_conditioner.sv
// key_conditioner: conditions the active-low DE1-SoC pushbuttons for the
// lab1 UI. Each key is synchronised (2 flops), debounced, edge-detected and,
// when KEY_REPEAT_EN is defined, auto-repeats while held. Without
// KEY_REPEAT_EN there is no repeat logic and step_pulse == press_pulse.
//
// Ports:
//   clk           system clock (CLOCK_50)
//   reset         asynchronous, active-high reset
//   key_n         [NKEYS] raw buttons, 0 = pressed, asynchronous to clk
//   pressed       [NKEYS] debounced level, 1 = held
//   press_pulse   [NKEYS] one cycle at the first cycle of pressed = 1
//   release_pulse [NKEYS] one cycle at the first cycle of pressed = 0
//   step_pulse    [NKEYS] one cycle on press and on every auto-repeat

// One key: synchroniser, debouncer, edge pulses, optional repeat FSM.
module key_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);
  // Elaboration-time configuration check.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      (64'(1) << CNT_W) <= 64'(REPEAT_DELAY) ||
      (64'(1) << CNT_W) <= 64'(REPEAT_RATE)) begin : g_bad_cfg
    $error("key_lane: invalid timing parameters for CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0, sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             db_flip;
  logic             pressed_nxt;

  always_comb begin
    s           = ~sync1;
    db_flip     = (s != pressed) && (cnt == DB_TC);
    pressed_nxt = db_flip ? s : pressed;
  end

  // Synchroniser resets to "released" so reset release never looks like an edge.
  // Edge pulses are computed from pressed_nxt so they land on the same cycle
  // as the new debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0         <= 1'b1;
      sync1         <= 1'b1;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync0         <= key_n;
      sync1         <= sync0;
      cnt           <= (s == pressed || db_flip) ? '0 : cnt + 1'b1;
      pressed       <= pressed_nxt;
      press_pulse   <= pressed_nxt & ~pressed;
      release_pulse <= ~pressed_nxt & pressed;
    end
  end

`ifdef KEY_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;

  localparam logic [CNT_W-1:0] RD_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_TC = CNT_W'(REPEAT_RATE - 1);

  rstate_t          rstate;
  logic [CNT_W-1:0] rtimer;

  // A debounced release (pressed_nxt = 0) wins over a terminal count on the
  // same edge, so no step is issued once the key is seen as released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate     <= IDLE;
      rtimer     <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (rstate)
        IDLE: begin
          rtimer <= '0;
          if (pressed_nxt && !pressed) begin
            step_pulse <= 1'b1;
            rstate     <= DELAY;
          end
        end
        DELAY: begin
          if (!pressed_nxt) begin
            rstate <= IDLE;
            rtimer <= '0;
          end else if (rtimer == RD_TC) begin
            step_pulse <= 1'b1;
            rtimer     <= '0;
            rstate     <= REPEAT;
          end else begin
            rtimer <= rtimer + 1'b1;
          end
        end
        REPEAT: begin
          if (!pressed_nxt) begin
            rstate <= IDLE;
            rtimer <= '0;
          end else if (rtimer == RR_TC) begin
            step_pulse <= 1'b1;
            rtimer     <= '0;
          end else begin
            rtimer <= rtimer + 1'b1;
          end
        end
        default: begin
          rstate <= IDLE;
          rtimer <= '0;
        end
      endcase
    end
  end
`else
  assign step_pulse = press_pulse;
`endif
endmodule

module key_conditioner #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] pressed,
  output logic [NKEYS-1:0] press_pulse,
  output logic [NKEYS-1:0] release_pulse,
  output logic [NKEYS-1:0] step_pulse
);
  // Keys are fully independent; one lane per bit.
  key_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .CNT_W          (CNT_W)
  ) u_lane [NKEYS-1:0] (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=5. Step expectations follow KEY_REPEAT_EN as built.
module tb_key_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] pressed, press_pulse, release_pulse, step_pulse;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // j = cycles since press acceptance; rel = cycle the debounced release lands.
  function automatic logic exp_step(input int j, input int rel);
`ifdef KEY_REPEAT_EN
    if (j >= rel) return 1'b0;
    if (j == 0) return 1'b1;
    return (j >= 20) && ((j - 20) % 5 == 0);
`else
    return (j == 0) && (rel > 0);
`endif
  endfunction

  bit bpat [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [15:0] acc;
    int          nstep;

    // Reset with keys released.
    key_n = 4'hF;
    reset = 1'b1;
    tick(); tick();
    chk("rst_pressed", pressed, 0);
    chk("rst_press_pulse", press_pulse, 0);
    chk("rst_release_pulse", release_pulse, 0);
    chk("rst_step_pulse", step_pulse, 0);
    reset = 1'b0;
    acc = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      acc |= {pressed, press_pulse, release_pulse, step_pulse};
    end
    chk("idle_after_reset", acc, 0);

    // Clean press of key 0: accepted 6 cycles after the raw edge.
    key_n[0] = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("k0_press_level", pressed[0], j == 6);
    end
    chk("k0_press_pulse_A", press_pulse, 4'b0001);
    chk("k0_step_A", step_pulse, 4'b0001);

    // Hold; raw release in cycle A+59 lands at A+65, suppressing that step.
    for (int j = 1; j <= 72; j++) begin
      tick();
      chk("k0_hold_step", step_pulse[0], exp_step(j, 65));
      chk("k0_hold_press", press_pulse[0], 0);
      chk("k0_release_pulse", release_pulse[0], j == 65);
      if (j == 59) key_n[0] = 1'b1;
    end
    chk("k0_released", pressed[0], 0);

    // Bounce on key 1: only the final, long-enough low is accepted.
    for (int i = 0; i <= 20; i++) begin
      key_n[1] = (i < 7) ? bpat[i] : 1'b0;
      tick();
      chk("k1_bounce_press", press_pulse[1], i == 12);
      chk("k1_bounce_step", step_pulse[1], i == 12);
    end
    key_n[1] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("k1_released", pressed, 0);

    // Keys 0 and 3 together; key 3 debounced release at A+22.
    key_n = 4'b0110;
    for (int j = 1; j <= 6; j++) tick();
    chk("k03_press_pulse_A", press_pulse, 4'b1001);
    chk("k03_step_A", step_pulse, 4'b1001);
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk("k0_dual_step", step_pulse[0], exp_step(j, 1000));
      chk("k3_dual_step", step_pulse[3], exp_step(j, 22));
      chk("k3_release_pulse", release_pulse[3], j == 22);
      if (j == 16) key_n[3] = 1'b1;
    end
    chk("k03_levels", pressed, 4'b0001);
    key_n[0] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("k0_dual_released", pressed, 0);

    // Key 2 held 100 cycles, then reset mid-hold.
    key_n[2] = 1'b0;
    for (int j = 1; j <= 6; j++) tick();
    chk("k2_press_pulse_A", press_pulse, 4'b0100);
    nstep = int'(step_pulse[2]);
    for (int j = 1; j < 100; j++) begin
      tick();
      nstep += int'(step_pulse[2]);
    end
`ifdef KEY_REPEAT_EN
    chk("k2_step_count", nstep, 17);
`else
    chk("k2_step_count", nstep, 1);
`endif
    #2 reset = 1'b1;
    #1;
    chk("midrst_pressed", pressed, 0);
    chk("midrst_pulses", {press_pulse, release_pulse, step_pulse}, 0);
    tick(); tick();
    chk("midrst_hold", {pressed, press_pulse, release_pulse, step_pulse}, 0);
    reset = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("k2_repress_level", pressed[2], j == 6);
      chk("k2_repress_pulse", press_pulse[2], j == 6);
    end
    chk("k2_repress_step", step_pulse, 4'b0100);
    chk("k2_no_release", release_pulse, 0);
    key_n[2] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("final_idle", pressed, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
